beam_sort_ctrl: RTL and testbench
=================================

Name: beam_sort_ctrl

Overview:
- Sequences the per-beam compare/sort datapath (COL parallel rank comparators) for PUSCH beam selection.
- Accumulates per-beam power vectors over a programmable number of symbols and hands the accumulated vector to the sort engine.
- Captures the returned per-beam rank scores, inverts them into a rank→beam table, and streams the strongest K beams (index and power) downstream for dimension reduction.

Parameters:
- IW, 32, bit width of one beam power word (unsigned)
- COL, 64, number of beams sorted in parallel
- SW, 8, width of rank score and beam index

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; latches config and starts a window (ignored unless IDLE)
- i_acc_num  in  8  symbols to accumulate; 0 treated as 1
- i_topk  in  SW  beams to emit; 0 or >COL clamped to COL
- i_pwr_data  in  COL*IW  per-beam power vector, beam b at [b*IW +: IW]
- i_pwr_valid  in  1  power vector valid
- o_pwr_ready  out  1  controller accepts power vector
- o_sort_data  out  COL*IW  accumulated vector to sort engine
- o_sort_valid  out  1  sort request valid
- i_sort_ready  in  1  sort engine accepts request
- i_sort_score  in  COL*SW  rank of beam b at [b*SW +: SW]; 0 = strongest
- i_sort_valid  in  1  scores valid (single-cycle)
- o_beam_idx  out  SW  selected beam index
- o_beam_pwr  out  IW  accumulated power of selected beam
- o_beam_valid  out  1  output beat valid
- o_beam_last  out  1  final beat (rank K-1)
- i_beam_ready  in  1  downstream ready
- o_busy  out  1  high in any state except IDLE
- o_err_dup  out  1  sticky: duplicate or out-of-range rank detected; cleared by accepted i_start

Behaviour:
- Reset (async assert, sync deassert in design): state IDLE. All outputs 0, accumulators and rank table 0.
- FSM states: IDLE, ACC, REQ, WAIT, BUILD, EMIT.
- IDLE: on i_start, latch acc_num (0→1) and topk (clamped), clear accumulators and symbol counter → ACC.
- ACC: o_pwr_ready=1. On each i_pwr_valid&o_pwr_ready:
  - acc[b] += pwr[b], per beam, saturating at 2^IW-1.
  - Symbol counter increments.
  - On the beat where the count reaches acc_num → REQ next cycle. The final beat is included in the sum.
- REQ: o_sort_valid=1, o_sort_data=acc, both held stable until i_sort_ready. Handshake cycle → WAIT.
- WAIT: on i_sort_valid, register all scores → BUILD. i_sort_valid outside WAIT is ignored.
- BUILD, exactly 1 cycle:
  - For each beam b, write tbl[score[b]] = b.
  - Set o_err_dup if any score ≥ COL or any two scores are equal. Conflicting writes resolve to the highest b.
  - → EMIT with rank counter r=0.
- EMIT:
  - o_beam_valid=1, o_beam_idx=tbl[r], o_beam_pwr=acc[tbl[r]], o_beam_last=(r==topk-1). Outputs are registered and stable while stalled.
  - On valid&ready: r++. If last → IDLE.
- Latency: last power beat → o_sort_valid asserted 1 cycle later. i_sort_valid → first o_beam_valid 2 cycles later.
- Throughput: one beam per cycle under continuous ready.
- Back-to-back: i_start in the same cycle as the last EMIT handshake is ignored (state is not yet IDLE); the caller retries.
- i_start while busy: ignored, no effect.
- Reset mid-operation: immediate return to IDLE, all outputs 0, o_err_dup cleared.
- Config inputs are sampled only at an accepted i_start.

Decomposition:
- Shared package beam_pkg: COL, IW, SW constants; typedef pwr_vec_t [COL-1:0][IW-1:0]; typedef score_vec_t [COL-1:0][SW-1:0]; enum ctrl_state_t {IDLE, ACC, REQ, WAIT, BUILD, EMIT}.
- One natural sub-module: beam_acc_sat, a COL-wide saturating accumulator with clear and enable.
- The FSM, rank table, and emit counter stay in the top module.

Test Plan:
- acc_num=1, topk=4, pwr[b]=b+1, sort engine returns score[b]=63-b → sort_data[b]=b+1; emits idx 63,62,61,60 with pwr 64,63,62,61; last on 60; o_err_dup=0.
- acc_num=3, three vectors all pwr[b]=0xFFFF_0000 → accumulators saturate at 0xFFFF_FFFF; sort_data all ones.
- topk=0, identity scores (score[b]=b) → 64 beats idx 0..63; last on idx 63 only.
- Stall i_sort_ready low 5 cycles, then toggle i_beam_ready 1-0-1 during EMIT → o_sort_data/o_sort_valid held stable; no skipped or duplicated beat.
- Scores with score[3]=score[7]=0 → o_err_dup=1; tbl[0]=7; error persists through IDLE and clears on the next accepted i_start.
- Assert i_reset_n low mid-EMIT (r=2) → all outputs 0 asynchronously; after release, a new i_start runs a clean window.

Source files
------------

// File: rtl/beam_pkg.sv
// Shared constants, vector types and FSM encoding for the beam sort controller.
package beam_pkg;

    localparam int IW  = 32;
    localparam int COL = 64;
    localparam int SW  = 8;
    localparam int CW  = $clog2(COL);

    typedef logic [COL-1:0][IW-1:0] pwr_vec_t;
    typedef logic [COL-1:0][SW-1:0] score_vec_t;

    typedef enum logic [2:0] {IDLE, ACC, REQ, WAIT, BUILD, EMIT} ctrl_state_t;

    function automatic logic [IW-1:0] sat_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[IW] ? '1 : s[IW-1:0];
    endfunction

    // Zero and anything wider than the beam count both mean "emit every beam".
    function automatic logic [SW-1:0] clamp_topk(input logic [SW-1:0] t);
        return (t == '0 || t > SW'(COL)) ? SW'(COL) : t;
    endfunction

endpackage

// File: rtl/beam_acc_sat.sv
// COL-wide saturating per-beam power accumulator with synchronous clear and enable.
module beam_acc_sat
    import beam_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_reset_n,
    input  logic     clr,
    input  logic     en,
    input  pwr_vec_t add,
    output pwr_vec_t acc
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            for (int b = 0; b < COL; b++) begin
                acc[b] <= sat_add(acc[b], add[b]);
            end
        end
    end

endmodule

// File: rtl/beam_sort_ctrl.sv
// Sequences accumulate -> sort request -> rank table build -> top-K beam emission.
module beam_sort_ctrl
    import beam_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [7:0]        i_acc_num,
    input  logic [SW-1:0]     i_topk,
    input  logic [COL*IW-1:0] i_pwr_data,
    input  logic              i_pwr_valid,
    output logic              o_pwr_ready,
    output logic [COL*IW-1:0] o_sort_data,
    output logic              o_sort_valid,
    input  logic              i_sort_ready,
    input  logic [COL*SW-1:0] i_sort_score,
    input  logic              i_sort_valid,
    output logic [SW-1:0]     o_beam_idx,
    output logic [IW-1:0]     o_beam_pwr,
    output logic              o_beam_valid,
    output logic              o_beam_last,
    input  logic              i_beam_ready,
    output logic              o_busy,
    output logic              o_err_dup
);

    ctrl_state_t         state_q, state_d;
    logic [7:0]          acc_num_q, sym_cnt_q;
    logic [SW-1:0]       topk_q, rank_q, rank_nxt;
    score_vec_t          score_q;
    score_vec_t          tbl_q, tbl_d;
    logic [COL-1:0]      seen;
    logic                dup_d;
    pwr_vec_t            acc;
    logic                start_ok, pwr_hs, beam_hs, acc_done;

    assign start_ok = (state_q == IDLE) && i_start;
    assign pwr_hs   = o_pwr_ready && i_pwr_valid;
    assign beam_hs  = o_beam_valid && i_beam_ready;
    assign acc_done = pwr_hs && (sym_cnt_q == acc_num_q - 8'd1);
    assign rank_nxt = rank_q + SW'(1);

    assign o_pwr_ready  = (state_q == ACC);
    assign o_sort_valid = (state_q == REQ);
    assign o_sort_data  = acc;
    assign o_busy       = (state_q != IDLE);

    beam_acc_sat u_acc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .clr       (start_ok),
        .en        (pwr_hs),
        .add       (i_pwr_data),
        .acc       (acc)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = ACC;
            ACC:     if (acc_done) state_d = REQ;
            REQ:     if (i_sort_ready) state_d = WAIT;
            WAIT:    if (i_sort_valid) state_d = BUILD;
            BUILD:   state_d = EMIT;
            EMIT:    if (beam_hs && o_beam_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Invert scores into rank->beam; later beams overwrite earlier ones on conflicting ranks.
    // NOTE: blocking assignments are correct here: seen/tbl_d must see earlier loop iterations.
    always_comb begin
        tbl_d = tbl_q;
        seen  = '0;
        dup_d = 1'b0;
        for (int b = 0; b < COL; b++) begin
            if (score_q[b] >= SW'(COL)) begin
                dup_d = 1'b1;
            end else begin
                if (seen[score_q[b][CW-1:0]]) dup_d = 1'b1;
                seen[score_q[b][CW-1:0]]  = 1'b1;
                tbl_d[score_q[b][CW-1:0]] = SW'(b);
            end
        end
    end

    // NOTE: the rank table is reset along with everything else so a window that skips ranks reads 0, not X.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_num_q    <= '0;
            sym_cnt_q    <= '0;
            topk_q       <= '0;
            rank_q       <= '0;
            score_q      <= '0;
            tbl_q        <= '0;
            o_err_dup    <= 1'b0;
            o_beam_valid <= 1'b0;
            o_beam_idx   <= '0;
            o_beam_pwr   <= '0;
            o_beam_last  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (i_start) begin
                    acc_num_q <= (i_acc_num == 8'd0) ? 8'd1 : i_acc_num;
                    topk_q    <= clamp_topk(i_topk);
                    sym_cnt_q <= '0;
                    o_err_dup <= 1'b0;
                end
                ACC:  if (pwr_hs) sym_cnt_q <= sym_cnt_q + 8'd1;
                WAIT: if (i_sort_valid) score_q <= i_sort_score;
                BUILD: begin
                    tbl_q        <= tbl_d;
                    o_err_dup    <= o_err_dup | dup_d;
                    rank_q       <= '0;
                    o_beam_valid <= 1'b1;
                    o_beam_idx   <= tbl_d[0];
                    o_beam_pwr   <= acc[tbl_d[0][CW-1:0]];
                    o_beam_last  <= (topk_q == SW'(1));
                end
                EMIT: if (beam_hs) begin
                    if (o_beam_last) begin
                        o_beam_valid <= 1'b0;
                        o_beam_idx   <= '0;
                        o_beam_pwr   <= '0;
                        o_beam_last  <= 1'b0;
                    end else begin
                        rank_q      <= rank_nxt;
                        o_beam_idx  <= tbl_q[rank_nxt[CW-1:0]];
                        o_beam_pwr  <= acc[tbl_q[rank_nxt[CW-1:0]][CW-1:0]];
                        o_beam_last <= (rank_nxt == topk_q - SW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_sort_ctrl.sv
// Directed scoreboard bench: expected sort requests and beam beats queued by stimulus, checked by monitors.
module tb_beam_sort_ctrl;
    import beam_pkg::*;

    typedef struct packed {
        logic [SW-1:0] idx;
        logic [IW-1:0] pwr;
        logic          last;
    } beat_t;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_start;
    logic [7:0]        i_acc_num;
    logic [SW-1:0]     i_topk;
    logic [COL*IW-1:0] i_pwr_data;
    logic              i_pwr_valid;
    logic              o_pwr_ready;
    logic [COL*IW-1:0] o_sort_data;
    logic              o_sort_valid;
    logic              i_sort_ready;
    logic [COL*SW-1:0] i_sort_score;
    logic              i_sort_valid;
    logic [SW-1:0]     o_beam_idx;
    logic [IW-1:0]     o_beam_pwr;
    logic              o_beam_valid;
    logic              o_beam_last;
    logic              i_beam_ready;
    logic              o_busy;
    logic              o_err_dup;

    int       checks = 0;
    int       errors = 0;
    int       beats_popped = 0;
    beat_t    exp_q[$];
    pwr_vec_t sort_q[$];

    beam_sort_ctrl dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (i_start),
        .i_acc_num    (i_acc_num),
        .i_topk       (i_topk),
        .i_pwr_data   (i_pwr_data),
        .i_pwr_valid  (i_pwr_valid),
        .o_pwr_ready  (o_pwr_ready),
        .o_sort_data  (o_sort_data),
        .o_sort_valid (o_sort_valid),
        .i_sort_ready (i_sort_ready),
        .i_sort_score (i_sort_score),
        .i_sort_valid (i_sort_valid),
        .o_beam_idx   (o_beam_idx),
        .o_beam_pwr   (o_beam_pwr),
        .o_beam_valid (o_beam_valid),
        .o_beam_last  (o_beam_last),
        .i_beam_ready (i_beam_ready),
        .o_busy       (o_busy),
        .o_err_dup    (o_err_dup)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pwr_vec_t vec_lin(input int mul, input int add);
        pwr_vec_t v;
        for (int b = 0; b < COL; b++) v[b] = IW'(b * mul + add);
        return v;
    endfunction

    function automatic pwr_vec_t vec_const(input logic [IW-1:0] val);
        pwr_vec_t v;
        for (int b = 0; b < COL; b++) v[b] = val;
        return v;
    endfunction

    function automatic score_vec_t sc_id();
        score_vec_t s;
        for (int b = 0; b < COL; b++) s[b] = SW'(b);
        return s;
    endfunction

    function automatic score_vec_t sc_rev();
        score_vec_t s;
        for (int b = 0; b < COL; b++) s[b] = SW'(COL - 1 - b);
        return s;
    endfunction

    function automatic score_vec_t sc_rot(input int k);
        score_vec_t s;
        for (int b = 0; b < COL; b++) s[b] = SW'((b + k) % COL);
        return s;
    endfunction

    function automatic score_vec_t sc_dup(input int a, input int c);
        score_vec_t s;
        s = sc_id();
        s[a] = '0;
        s[c] = '0;
        return s;
    endfunction

    task automatic push_beat(input int idx, input logic [IW-1:0] pwr, input logic last);
        beat_t e;
        e.idx  = SW'(idx);
        e.pwr  = pwr;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Beam monitor: compares every presented beat (including stalled ones) against the queue head.
    always @(negedge i_clk) begin
        if (i_reset_n && o_beam_valid) begin
            check("beam_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                check("beam_idx",  64'(o_beam_idx),  64'(exp_q[0].idx));
                check("beam_pwr",  64'(o_beam_pwr),  64'(exp_q[0].pwr));
                check("beam_last", 64'(o_beam_last), 64'(exp_q[0].last));
                if (i_beam_ready) begin
                    void'(exp_q.pop_front());
                    beats_popped++;
                end
            end
        end
    end

    // Sort-request monitor: data must match, and stay matched while the request is stalled.
    always @(negedge i_clk) begin
        if (i_reset_n && o_sort_valid) begin
            check("sort_expected", 64'(sort_q.size() > 0), 64'd1);
            if (sort_q.size() > 0) begin
                int bad = 0;
                for (int b = COL - 1; b >= 0; b--)
                    if (o_sort_data[b*IW +: IW] !== sort_q[0][b]) bad = b;
                check("sort_data", 64'(o_sort_data[bad*IW +: IW]), 64'(sort_q[0][bad]));
                if (i_sort_ready) void'(sort_q.pop_front());
            end
        end
    end

    task automatic do_start(input logic [7:0] an, input logic [SW-1:0] tk);
        @(posedge i_clk); #1;
        i_start = 1'b1; i_acc_num = an; i_topk = tk;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        check("start_busy", 64'(o_busy), 64'd1);
    endtask

    task automatic send_pwr(input pwr_vec_t v);
        int n = 0;
        i_pwr_data  = v;
        i_pwr_valid = 1'b1;
        @(negedge i_clk);
        while (!o_pwr_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("pwr_ready_wait", 64'(o_pwr_ready), 64'd1);
        @(posedge i_clk); #1;
        i_pwr_valid = 1'b0;
    endtask

    // Acts as the sort engine; during a stall also pokes i_start and a stray i_sort_valid, both to be ignored.
    task automatic sort_phase(input pwr_vec_t exp, input score_vec_t sc, input int stall);
        sort_q.push_back(exp);
        @(negedge i_clk);
        check("sort_valid_latency", 64'(o_sort_valid), 64'd1);
        for (int i = 0; i <= stall; i++) begin
            @(posedge i_clk); #1;
            i_start      = (i == 0 && stall > 0);
            i_sort_valid = (i == 0 && stall > 0);
            i_sort_score = '0;
            i_acc_num    = 8'd5;
            i_topk       = SW'(1);
        end
        i_sort_ready = 1'b1;
        @(posedge i_clk); #1;
        i_sort_ready = 1'b0;
        i_sort_valid = 1'b1;
        i_sort_score = sc;
        @(posedge i_clk); #1;
        i_sort_valid = 1'b0;
        @(negedge i_clk);
        check("beam_valid_early", 64'(o_beam_valid), 64'd0);
        @(negedge i_clk);
        check("beam_valid_latency", 64'(o_beam_valid), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 300) begin
            @(negedge i_clk); #1;
            n++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_idle",  64'(o_busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       64'(o_busy),       64'd0);
        check({tag, "_pwr_ready"},  64'(o_pwr_ready),  64'd0);
        check({tag, "_sort_valid"}, 64'(o_sort_valid), 64'd0);
        check({tag, "_sort_data"},  64'(|o_sort_data), 64'd0);
        check({tag, "_beam_valid"}, 64'(o_beam_valid), 64'd0);
        check({tag, "_beam_idx"},   64'(o_beam_idx),   64'd0);
        check({tag, "_beam_pwr"},   64'(o_beam_pwr),   64'd0);
        check({tag, "_beam_last"},  64'(o_beam_last),  64'd0);
        check({tag, "_err_dup"},    64'(o_err_dup),    64'd0);
    endtask

    initial begin
        int base;
        i_reset_n = 1'b0; i_start = 1'b0; i_acc_num = '0; i_topk = '0;
        i_pwr_data = '0; i_pwr_valid = 1'b0; i_sort_ready = 1'b0;
        i_sort_score = '0; i_sort_valid = 1'b0; i_beam_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_reset_n = 1'b1;

        // Single symbol, reversed ranking, top 4.
        do_start(8'd1, SW'(4));
        send_pwr(vec_lin(1, 1));
        for (int r = 0; r < 4; r++) push_beat(63 - r, IW'(64 - r), r == 3);
        sort_phase(vec_lin(1, 1), sc_rev(), 0);
        check("t1_err_dup", 64'(o_err_dup), 64'd0);
        wait_drain();

        // Three symbols saturating every accumulator.
        do_start(8'd3, SW'(1));
        send_pwr(vec_const(32'hFFFF_0000));
        check("t2_not_done_1", 64'(o_sort_valid), 64'd0);
        send_pwr(vec_const(32'hFFFF_0000));
        check("t2_not_done_2", 64'(o_sort_valid), 64'd0);
        send_pwr(vec_const(32'hFFFF_0000));
        push_beat(0, 32'hFFFF_FFFF, 1'b1);
        sort_phase(vec_const(32'hFFFF_FFFF), sc_id(), 0);
        wait_drain();

        // topk = 0 means all 64 beams, identity ranking.
        do_start(8'd1, SW'(0));
        send_pwr(vec_lin(16, 5));
        for (int r = 0; r < COL; r++) push_beat(r, IW'(16 * r + 5), r == COL - 1);
        sort_phase(vec_lin(16, 5), sc_id(), 0);
        wait_drain();

        // Sort-ready stall with ignored start, then downstream stall 1-0-1.
        do_start(8'd2, SW'(6));
        send_pwr(vec_const(32'd100));
        send_pwr(vec_lin(1, 0));
        for (int r = 0; r < 6; r++) push_beat((r + 59) % 64, IW'(100 + (r + 59) % 64), r == 5);
        sort_phase(vec_lin(1, 100), sc_rot(5), 5);
        @(posedge i_clk); #1;
        i_beam_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_beam_ready = 1'b1;
        wait_drain();

        // Duplicate ranks: beams 0,3,7 all claim rank 0, highest beam wins.
        do_start(8'd1, SW'(3));
        send_pwr(vec_lin(1, 1000));
        push_beat(7, 32'd1007, 1'b0);
        push_beat(1, 32'd1001, 1'b0);
        push_beat(2, 32'd1002, 1'b1);
        sort_phase(vec_lin(1, 1000), sc_dup(3, 7), 0);
        check("t5_err_dup_set", 64'(o_err_dup), 64'd1);
        wait_drain();
        repeat (3) @(posedge i_clk);
        #1;
        check("t5_err_dup_idle", 64'(o_err_dup), 64'd1);

        // Reset during emission at rank 2.
        do_start(8'd1, SW'(8));
        check("t6_err_dup_cleared", 64'(o_err_dup), 64'd0);
        send_pwr(vec_lin(1, 0));
        push_beat(5, 32'd5, 1'b0);
        for (int r = 1; r < 8; r++) push_beat(r, IW'(r), r == 7);
        base = beats_popped;
        sort_phase(vec_lin(1, 0), sc_dup(5, 5), 0);
        check("t6_err_dup_set", 64'(o_err_dup), 64'd1);
        for (int n = 0; n < 50 && beats_popped < base + 2; n++) begin
            @(negedge i_clk); #1;
        end
        check("t6_beats_before_reset", 64'(beats_popped - base), 64'd2);
        @(posedge i_clk); #1;
        i_reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        sort_q.delete();
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;

        // Clean window after reset; acc_num = 0 behaves as 1.
        do_start(8'd0, SW'(2));
        send_pwr(vec_lin(7, 0));
        push_beat(63, 32'd441, 1'b0);
        push_beat(62, 32'd434, 1'b1);
        sort_phase(vec_lin(7, 0), sc_rev(), 0);
        wait_drain();
        check("t7_err_dup", 64'(o_err_dup), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
